softmax_argmax: RTL
===================

# softmax_argmax

Downstream consumer of the FP32 softmax stage. Captures the four softmax outputs when the softmax `Done` level rises and scans the valid entries `0..N` sequentially, one per cycle. It produces the winning index, its probability, and a confidence flag against a fixed threshold. Results are presented to the next stage (classifier / decision logic) on a valid/ready handshake.

## Interface

Parameters:
- `DATALENGTH`, 32: FP32 word width.
- `INPUTMAX`, 2: `N` is `INPUTMAX+1` bits wide; 4 entries.
- `THRESH`, 32'h3F000000: confidence threshold (0.5).

Ports:
- `Clock`, in, 1: clock.
- `Reset`, in, 1: asynchronous, active-high.
- `SmDone`, in, 1: softmax `Done` level. It stays high until softmax reset.
- `Y0`..`Y3`, in, 32 each: softmax FP32 outputs.
- `N`, in, 3: index of the last valid entry (entries `0..N` are valid).
- `OutReady`, in, 1: consumer ready.
- `OutValid`, out, 1: result valid.
- `Index`, out, 2: argmax index.
- `MaxVal`, out, 32: FP32 value at `Index`.
- `Confident`, out, 1: `MaxVal >= THRESH`.
- `AllNaN`, out, 1: every scanned entry was NaN.
- `Busy`, out, 1: state is not IDLE.
- `Overrun`, out, 1: sticky; a new `SmDone` rise arrived while busy.

## Operation

- Edge detect: `DonePrev <= SmDone` every cycle. `Rise = SmDone & ~DonePrev`. `DonePrev` resets to 1, so a `SmDone` that is already high after reset does not trigger a scan.
- `Nc = min(N, 3)`. Values 4..7 clamp to 3.
- Compare key, for non-NaN values:
  - Canonicalize -0 to +0.
  - `key = sign ? ~x : x ^ 32'h80000000`.
  - Compare keys as unsigned.
- NaN is exponent 8'hFF with mantissa != 0. A NaN entry never wins against a non-NaN entry.
- Tie-break: strict greater-than, so the lowest index wins.
- State IDLE:
  - On `Rise`, capture `Y0..Y3` and `Nc` into registers.
  - Load `Best = Y0`, `BestIdx = 0`, `BestNaN = isNaN(Y0)`, `Cnt = 1`, then go to SCAN.
- State SCAN, per posedge:
  - If `Cnt <= Nc`: take entry `E = buf[Cnt]`. Replace `Best` if `BestNaN & !isNaN(E)`, or if `!BestNaN & !isNaN(E) & key(E) > key(Best)`. Then `Cnt++`.
  - Otherwise: go to HOLD, set `OutValid <= 1`, and register `Index`, `MaxVal`, `Confident`, `AllNaN`.
  - `Confident = !BestNaN & key(Best) >= key(THRESH)`.
  - `AllNaN = BestNaN`.
- State HOLD:
  - Outputs are held stable.
  - On a posedge with `OutValid & OutReady`: `OutValid <= 0`, go to IDLE.
- A `Rise` seen in SCAN or HOLD is ignored and sets `Overrun <= 1`. `Overrun` clears only on `Reset`.
- `Cnt` is 3 bits wide so that it does not wrap at `Nc = 3`.

## Timing

- Reset values:
  - `OutValid`, `Index`, `MaxVal`, `Confident`, `AllNaN`, `Busy`, `Overrun` = 0.
  - Internal state IDLE, `DonePrev` = 1.
- `Rise` is sampled at posedge k. Entries 1..Nc are compared at posedges k+1..k+Nc. `OutValid` is high after posedge k+Nc+1, i.e. latency Nc+1 cycles (1..4).
- `Busy` is high from posedge k until the handshake posedge.
- Handshake: a transfer occurs on a posedge with `OutValid & OutReady`. `OutReady` may be high early; the transfer then takes one cycle in HOLD. There is no combinational ready-to-valid path.
- A new scan starts no earlier than the posedge after the return to IDLE. It requires a fresh `SmDone` rise.
- `Reset` mid-SCAN or mid-HOLD: all outputs return to reset values immediately (asynchronously) and the in-flight result is discarded.

## Test plan

- Basic argmax: Y={3E000000, 3F000000, 3E800000, 3E000000}, N=3, `SmDone` rises, `OutReady`=1 -> `OutValid` after 4 cycles, Index=1, MaxVal=3F000000, Confident=1, AllNaN=0.
- Tie and threshold: Y0=Y2=3EC00000, Y1=Y3=3E000000, N=3 -> Index=0, MaxVal=3EC00000, Confident=0.
- Range handling:
  - Y={3E000000, 3E800000, 3F000000, 3F800000}, N=1 -> Index=1, latency 2 cycles.
  - Same Y with N=7 -> Index=3, latency 4 cycles.
- NaN and zero:
  - Y0=7FC00000, Y1=3E800000, N=1 -> Index=1.
  - All four 7FC00000, N=3 -> AllNaN=1, Index=0, Confident=0.
  - Y0=80000000, Y1=00000000, N=1 -> Index=0 (zeros compare equal).
- Backpressure and overrun: hold `OutReady`=0 for 10 cycles -> Index and MaxVal stable, Busy=1. Drop `SmDone` and raise it during HOLD -> Overrun=1, result unchanged. Raise `OutReady` -> `OutValid` drops after 1 cycle.
- Reset mid-SCAN: assert `Reset` at cycle 2 of the scan while `SmDone` stays high -> all outputs 0. After release, no new scan starts until `SmDone` goes low then high.

Source files
------------

// File: rtl/softmax_argmax.sv
// softmax_argmax
//   Captures the four FP32 softmax outputs on a rising edge of the softmax
//   Done level. It scans entries 0..min(N,3) one per cycle and presents the
//   argmax index, its value, a confidence flag and an all-NaN flag on a
//   valid/ready handshake.
// Ports:
//   Clock, Reset    clock, asynchronous active-high reset
//   SmDone          softmax Done level (a rise starts a scan)
//   Y0..Y3          softmax FP32 outputs
//   N               index of the last valid entry (4..7 clamp to 3)
//   OutReady        consumer ready
//   OutValid        result valid
//   Index, MaxVal   winning index and its FP32 value
//   Confident       MaxVal >= THRESH (never for NaN)
//   AllNaN          every scanned entry was NaN
//   Busy            a scan or an unacknowledged result is in flight
//   Overrun         sticky: a Done rise arrived while busy
module softmax_argmax #(
  parameter int                    DATALENGTH = 32,
  parameter int                    INPUTMAX   = 2,
  parameter logic [DATALENGTH-1:0] THRESH     = 32'h3F000000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SmDone,
  input  logic [DATALENGTH-1:0] Y0,
  input  logic [DATALENGTH-1:0] Y1,
  input  logic [DATALENGTH-1:0] Y2,
  input  logic [DATALENGTH-1:0] Y3,
  input  logic [INPUTMAX:0]     N,
  input  logic                  OutReady,
  output logic                  OutValid,
  output logic [1:0]            Index,
  output logic [DATALENGTH-1:0] MaxVal,
  output logic                  Confident,
  output logic                  AllNaN,
  output logic                  Busy,
  output logic                  Overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [INPUTMAX:0] N_LAST = (INPUTMAX + 1)'(3);

  // NaN: all-ones exponent with a non-zero mantissa (infinities are ordinary values)
  function automatic logic is_nan(input logic [DATALENGTH-1:0] x);
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Monotonic unsigned key for non-NaN floats; -0 folds onto +0 so zeros tie
  function automatic logic [DATALENGTH-1:0] fp_key(input logic [DATALENGTH-1:0] x);
    logic [DATALENGTH-1:0] c;
    c = (x[30:0] == 31'd0) ? 32'h00000000 : x;
    fp_key = c[31] ? ~c : (c ^ 32'h80000000);
  endfunction

  state_t                state_q;
  logic                  done_prev_q;
  logic [DATALENGTH-1:0] buf_q [0:3];
  logic [2:0]            nc_q;
  logic [2:0]            cnt_q;
  logic [DATALENGTH-1:0] best_q;
  logic [1:0]            best_idx_q;
  logic                  best_nan_q;
  logic                  out_valid_q;
  logic [1:0]            index_q;
  logic [DATALENGTH-1:0] max_val_q;
  logic                  confident_q;
  logic                  all_nan_q;
  logic                  busy_q;
  logic                  overrun_q;

  logic                  rise_d;
  logic [2:0]            nc_d;
  logic [DATALENGTH-1:0] entry_d;
  logic                  entry_nan_d;
  logic                  replace_d;
  logic                  confident_d;

  // Edge detect, range clamp, per-entry compare and confidence decision
  always_comb begin
    rise_d      = 1'b0;
    nc_d        = 3'd0;
    entry_d     = buf_q[cnt_q[1:0]];
    entry_nan_d = 1'b0;
    replace_d   = 1'b0;
    confident_d = 1'b0;

    rise_d = SmDone & ~done_prev_q;

    if (N > N_LAST) begin
      nc_d = 3'd3;
    end else begin
      nc_d = N[2:0];
    end

    entry_nan_d = is_nan(entry_d);
    // Strict greater-than keeps the lowest index on ties; a NaN never displaces a number
    if (best_nan_q) begin
      replace_d = ~entry_nan_d;
    end else begin
      replace_d = ~entry_nan_d && (fp_key(entry_d) > fp_key(best_q));
    end

    confident_d = ~best_nan_q && (fp_key(best_q) >= fp_key(THRESH));
  end

  // Control FSM, scan datapath and registered result outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      done_prev_q <= 1'b1;   // a Done already high out of reset is not a rise
      buf_q[0]    <= 32'h00000000;
      buf_q[1]    <= 32'h00000000;
      buf_q[2]    <= 32'h00000000;
      buf_q[3]    <= 32'h00000000;
      nc_q        <= 3'd0;
      cnt_q       <= 3'd0;
      best_q      <= 32'h00000000;
      best_idx_q  <= 2'd0;
      best_nan_q  <= 1'b0;
      out_valid_q <= 1'b0;
      index_q     <= 2'd0;
      max_val_q   <= 32'h00000000;
      confident_q <= 1'b0;
      all_nan_q   <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_prev_q <= SmDone;
      case (state_q)
        S_IDLE: begin
          if (rise_d) begin
            buf_q[0]   <= Y0;
            buf_q[1]   <= Y1;
            buf_q[2]   <= Y2;
            buf_q[3]   <= Y3;
            nc_q       <= nc_d;
            best_q     <= Y0;
            best_idx_q <= 2'd0;
            best_nan_q <= is_nan(Y0);
            cnt_q      <= 3'd1;
            busy_q     <= 1'b1;
            state_q    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (rise_d) begin
            overrun_q <= 1'b1;
          end
          // cnt_q is 3 bits so it reaches 4 and terminates the scan at Nc = 3
          if (cnt_q <= nc_q) begin
            if (replace_d) begin
              best_q     <= entry_d;
              best_idx_q <= cnt_q[1:0];
              best_nan_q <= entry_nan_d;
            end
            cnt_q <= cnt_q + 3'd1;
          end else begin
            out_valid_q <= 1'b1;
            index_q     <= best_idx_q;
            max_val_q   <= best_q;
            confident_q <= confident_d;
            all_nan_q   <= best_nan_q;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (rise_d) begin
            overrun_q <= 1'b1;
          end
          if (out_valid_q && OutReady) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign OutValid  = out_valid_q;
  assign Index     = index_q;
  assign MaxVal    = max_val_q;
  assign Confident = confident_q;
  assign AllNaN    = all_nan_q;
  assign Busy      = busy_q;
  assign Overrun   = overrun_q;

endmodule
